reaction_stimulus: RTL
======================

REACTION_STIMULUS -- requirements
Module: reaction_stimulus

Interface
REQ-001 Parameters: N_LAMPS, default 10, number of start lamps; STEP_MS, default 500, ms between lamp steps; DELAY_MIN, default 250, minimum random delay in ms; TIMEOUT_MS, default 9999, maximum wait for stop in ms.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
REQ-004 tick_ms  input  1  one-clk-wide pulse per millisecond; time base for every ms count.
REQ-005 trigger  input  1  level; request to start a round.
REQ-006 stop  input  1  level; player button.
REQ-007 lamps  output  N_LAMPS  start-lamp pattern.
REQ-008 go  output  1  one-clk pulse at lights-out; drives the reaction counter's clear/start.
REQ-009 counting  output  1  high while waiting for the player.
REQ-010 false_start  output  1  sticky; stop pressed before go.
REQ-011 time_out  output  1  sticky; no stop within TIMEOUT_MS.
REQ-012 delay_ms  output  13  random delay sampled for the current round.

Function
REQ-013 FSM states SHALL be IDLE, LIGHTS, DELAY, GO, WAIT.
REQ-014 IDLE: lamps=0, counting=0; trigger=1 -> LIGHTS, clear false_start and time_out, lamps=1 (lamp 0 on), clear ms counter.
REQ-015 trigger SHALL be ignored in every state except IDLE.
REQ-016 LIGHTS: ms counter advances only on tick_ms; every STEP_MS ticks, lamps <= {lamps[N_LAMPS-2:0],1'b1}; STEP_MS ticks after all lamps are on -> DELAY.
REQ-017 Entry to DELAY SHALL latch delay_ms = lfsr[11:0] + DELAY_MIN (13-bit, no overflow) and clear the ms counter; lamps stay all-on.
REQ-018 DELAY: after delay_ms ticks -> GO.
REQ-019 GO lasts exactly one clk: go=1, lamps=0; next state WAIT.
REQ-020 WAIT: counting=1; stop=1 -> IDLE; TIMEOUT_MS ticks without stop -> IDLE with time_out=1.
REQ-021 stop=1 in LIGHTS or DELAY SHALL set false_start=1 and return to IDLE (lamps=0, go never pulses).
REQ-022 stop and tick_ms in the same cycle: stop wins; the tick is not counted.
REQ-023 stop already high on the GO cycle SHALL be acted on in the first WAIT cycle (minimum reaction 1 clk).
REQ-024 LFSR: 14-bit Fibonacci, taps 14,13,12,2, advances every clk regardless of state, never all-zero.
REQ-025 ms counter: 14 bits, cleared on every state entry, never wraps within a legal state.

Reset
REQ-026 reset=1 SHALL force IDLE on the next posedge clk from any state, with lamps=0, go=0, counting=0, false_start=0, time_out=0, delay_ms=0, ms counter=0, lfsr=14'h2A5B.
REQ-027 reset SHALL take priority over trigger, stop, and tick_ms in the same cycle.

Structure
REQ-028 State encodings (3-bit) and LFSR seed/tap constants SHALL live in shared package reaction_pkg, for reuse by the counter and display blocks.
REQ-029 LFSR SHALL be a separate sub-module lfsr14 (clk, reset, enable, q[13:0]); all other logic stays in reaction_stimulus.

Verification (bench parameters N_LAMPS=4, STEP_MS=2, DELAY_MIN=3, TIMEOUT_MS=20; tick_ms every 4 clk)
REQ-030 Normal round: trigger pulse -> lamps 0001,0011,0111,1111 at 2-tick spacing; DELAY entered 2 ticks later; go pulses one clk exactly delay_ms ticks later with lamps=0000; stop 5 ticks later -> IDLE, counting drops.
REQ-031 False start: stop during DELAY -> false_start=1, lamps=0000, go stays 0; next trigger clears false_start.
REQ-032 Timeout: no stop after go -> time_out=1 and IDLE exactly 20 ticks after go.
REQ-033 Reset mid-DELAY and mid-WAIT -> all outputs at reset values on the next clk; lfsr reloads 14'h2A5B, so the next round's delay_ms equals the first round's after reset.
REQ-034 Corner cases: trigger held high through a full round -> no restart until IDLE; stop coincident with tick_ms at the last DELAY tick -> false_start=1, go=0; stop high on the GO cycle -> IDLE after exactly one WAIT cycle.
REQ-035 Delay range: 1000 rounds -> every delay_ms is in [3, 4098], with at least 500 distinct values.

Source files
------------

// File: rtl/reaction_pkg.sv
// reaction_pkg: state encodings, LFSR constants and delay helper shared by the reaction-timer blocks
package reaction_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LIGHTS = 3'd1,
    DELAY  = 3'd2,
    GO     = 3'd3,
    WAIT   = 3'd4
  } state_t;
  localparam logic [13:0] LFSR_SEED = 14'h2A5B;
  localparam logic [13:0] LFSR_TAPS = 14'h3802;
  function automatic logic [12:0] round_delay(input logic [13:0] q, input logic [12:0] dmin);
    return 13'(q & 14'h0FFF) + dmin;
  endfunction
endpackage

// File: rtl/lfsr14.sv
// lfsr14: free-running 14-bit Fibonacci LFSR (x^14+x^13+x^12+x^2+1) with a fixed non-zero seed
module lfsr14
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [13:0] q
);
  logic [13:0] q_q, q_d;
  assign q_d = enable ? {q_q[12:0], ^(q_q & LFSR_TAPS)} : q_q;
  assign q = q_q;
  // shift register; xor feedback from a non-zero seed never reaches all-zero
  always_ff @(posedge clk) q_q <= reset ? LFSR_SEED : q_d;
endmodule

// File: rtl/reaction_stimulus.sv
// reaction_stimulus: start-lamp sequence, random hold-off, go pulse and timed reaction window
module reaction_stimulus
  import reaction_pkg::*;
#(
  parameter int N_LAMPS    = 10,
  parameter int STEP_MS    = 500,
  parameter int DELAY_MIN  = 250,
  parameter int TIMEOUT_MS = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_ms,
  input  logic               trigger,
  input  logic               stop,
  output logic [N_LAMPS-1:0] lamps,
  output logic               go,
  output logic               counting,
  output logic               false_start,
  output logic               time_out,
  output logic [12:0]        delay_ms
);
  localparam logic [13:0] STEP = 14'(STEP_MS);
  localparam logic [13:0] TMO  = 14'(TIMEOUT_MS);
  localparam logic [12:0] DMIN = 13'(DELAY_MIN);
  state_t             state_q, state_d;
  logic [N_LAMPS-1:0] lamps_q, lamps_d;
  logic [13:0]        cnt_q, cnt_d, cnt_inc;
  logic               fs_q, fs_d, to_q, to_d;
  logic [12:0]        delay_q, delay_d;
  logic [13:0]        lfsr_q;
  lfsr14 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .enable(1'b1),
    .q     (lfsr_q)
  );
  assign lamps       = lamps_q;
  assign go          = state_q == GO;
  assign counting    = state_q == WAIT;
  assign false_start = fs_q;
  assign time_out    = to_q;
  assign delay_ms    = delay_q;
  // next state: stop outranks a same-cycle tick, and the ms counter restarts on every state entry
  always_comb begin
    state_d = state_q;
    lamps_d = lamps_q;
    cnt_d   = cnt_q;
    fs_d    = fs_q;
    to_d    = to_q;
    delay_d = delay_q;
    cnt_inc = cnt_q + 14'd1;
    unique case (state_q)
      IDLE: if (trigger) begin
        state_d = LIGHTS;
        lamps_d = N_LAMPS'(1);
        cnt_d   = '0;
        fs_d    = 1'b0;
        to_d    = 1'b0;
      end
      LIGHTS: if (stop) begin
        state_d = IDLE;
        lamps_d = '0;
        cnt_d   = '0;
        fs_d    = 1'b1;
      end else if (tick_ms) begin
        cnt_d = cnt_inc == STEP ? '0 : cnt_inc;
        if (cnt_inc == STEP && &lamps_q) begin
          state_d = DELAY;
          delay_d = round_delay(lfsr_q, DMIN);
        end else if (cnt_inc == STEP) begin
          lamps_d = {lamps_q[N_LAMPS-2:0], 1'b1};
        end
      end
      DELAY: if (stop) begin
        state_d = IDLE;
        lamps_d = '0;
        cnt_d   = '0;
        fs_d    = 1'b1;
      end else if (tick_ms) begin
        cnt_d = cnt_inc == {1'b0, delay_q} ? '0 : cnt_inc;
        if (cnt_inc == {1'b0, delay_q}) begin
          state_d = GO;
          lamps_d = '0;
        end
      end
      GO: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (stop) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (tick_ms) begin
        cnt_d = cnt_inc == TMO ? '0 : cnt_inc;
        if (cnt_inc == TMO) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        lamps_d = '0;
        cnt_d   = '0;
      end
    endcase
  end
  // state registers with synchronous reset to an idle, dark, cleared round
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lamps_q <= '0;
      cnt_q   <= '0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      lamps_q <= lamps_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
      delay_q <= delay_d;
    end
  end
endmodule
